// File: rtl/switch_control_pkg.sv
// Shared constants, port indices and FSM encoding for the Phoenix switch controller.
package switch_control_pkg;

    localparam int unsigned NPORT      = 5;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned PORT_W     = 3;

    typedef logic [PORT_W-1:0] port_idx_t;

    localparam port_idx_t EAST  = 3'd0;
    localparam port_idx_t WEST  = 3'd1;
    localparam port_idx_t NORTH = 3'd2;
    localparam port_idx_t SOUTH = 3'd3;
    localparam port_idx_t LOCAL = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ROUTE = 2'd2,
        GRANT = 2'd3
    } sc_state_t;

    // Modular add of two port indices already below n.
    function automatic port_idx_t wrap_add(input port_idx_t a, input port_idx_t b,
                                           input int unsigned n);
        int unsigned s;
        s = 32'(a) + 32'(b);
        if (s >= n) s = s - n;
        return port_idx_t'(s);
    endfunction

endpackage

// File: rtl/switch_control_if.sv
// Request/grant and crossbar-select bundle between input buffers and the switch controller.
interface switch_control_if;
    import switch_control_pkg::*;

    logic [NPORT-1:0]            h;
    logic [NPORT*ADDR_WIDTH-1:0] data;
    logic [NPORT-1:0]            sender;
    logic [NPORT-1:0]            ack_h;
    logic [NPORT-1:0]            free;
    logic [NPORT*PORT_W-1:0]     mux_in;
    logic [NPORT*PORT_W-1:0]     mux_out;

    modport master (
        output h, data, sender,
        input  ack_h, free, mux_in, mux_out
    );

    modport slave (
        input  h, data, sender,
        output ack_h, free, mux_in, mux_out
    );

endinterface

// File: rtl/switch_control_arbiter.sv
// Fixed-priority arbiter: lowest-index active request wins when enabled.
module FixedPriorityArbiter
    import switch_control_pkg::*;
#(
    parameter int unsigned N = NPORT
) (
    input  logic [N-1:0] requests,
    input  logic         enable,
    output logic         isOutputSelected,
    output port_idx_t    selectedOutput
);

    logic      found;
    port_idx_t idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (enable) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (requests[i] && !found) begin
                    found = 1'b1;
                    idx   = port_idx_t'(i);
                end
            end
        end
        isOutputSelected = found;
        selectedOutput   = idx;
    end

endmodule

// File: rtl/switch_control_xy_route.sv
// Dimension-ordered XY routing: resolve X first, then Y, else deliver locally.
module xy_route_unit
    import switch_control_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH_P = ADDR_WIDTH,
    parameter logic [ADDR_WIDTH_P-1:0]  ADDRESS      = 8'h11
) (
    input  logic [ADDR_WIDTH_P-1:0] addr_i,
    output port_idx_t               port_o
);

    localparam int unsigned HW = ADDR_WIDTH_P / 2;
    localparam logic [ADDR_WIDTH_P-HW-1:0] MY_X = ADDRESS[ADDR_WIDTH_P-1:HW];
    localparam logic [HW-1:0]              MY_Y = ADDRESS[HW-1:0];

    logic [ADDR_WIDTH_P-HW-1:0] dx;
    logic [HW-1:0]              dy;

    always_comb begin
        dx = addr_i[ADDR_WIDTH_P-1:HW];
        dy = addr_i[HW-1:0];
        if (dx > MY_X)      port_o = EAST;
        else if (dx < MY_X) port_o = WEST;
        else if (dy > MY_Y) port_o = NORTH;
        else if (dy < MY_Y) port_o = SOUTH;
        else                port_o = LOCAL;
    end

endmodule

// File: rtl/switch_control.sv
// Phoenix router switch allocator: rotating-priority pick, XY route, grant and
// crossbar select bookkeeping, with per-output release when the sender stops.
module switch_control
    import switch_control_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] ADDRESS = 8'h11
) (
    input  logic            clock,
    input  logic            reset,
    switch_control_if.slave sw
);

    sc_state_t  state_q, state_d;
    port_idx_t  last_q, last_d;
    port_idx_t  sel_q, sel_d;
    port_idx_t  target_q, target_d;
    logic [NPORT-1:0] free_q, free_d;
    port_idx_t  mux_in_q  [NPORT];
    port_idx_t  mux_in_d  [NPORT];
    port_idx_t  mux_out_q [NPORT];
    port_idx_t  mux_out_d [NPORT];

    port_idx_t        start;
    logic [NPORT-1:0] rot_req;
    logic             arb_valid;
    port_idx_t        arb_idx;
    logic [ADDR_WIDTH-1:0] route_addr;
    port_idx_t        route_port;

    // Rotating the request vector makes the fixed-priority arbiter start just past the last winner.
    always_comb begin
        start = wrap_add(last_q, port_idx_t'(1), NPORT);
        for (int unsigned i = 0; i < NPORT; i++) begin
            rot_req[i] = sw.h[wrap_add(port_idx_t'(i), start, NPORT)];
        end
    end

    FixedPriorityArbiter #(.N(NPORT)) u_arb (
        .requests         (rot_req),
        .enable           (state_q == ARB),
        .isOutputSelected (arb_valid),
        .selectedOutput   (arb_idx)
    );

    always_comb begin
        route_addr = sw.data[32'(sel_q)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    xy_route_unit #(.ADDR_WIDTH_P(ADDR_WIDTH), .ADDRESS(ADDRESS)) u_xy (
        .addr_i (route_addr),
        .port_o (route_port)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        target_d = target_q;
        unique case (state_q)
            IDLE: begin
                if (|sw.h) state_d = ARB;
            end
            ARB: begin
                if (arb_valid) begin
                    sel_d   = wrap_add(arb_idx, start, NPORT);
                    state_d = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: begin
                target_d = route_port;
                if (sw.h[sel_q] && free_q[route_port]) state_d = GRANT;
                else                                   state_d = IDLE;
            end
            GRANT: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sw.ack_h = '0;
        if (state_q == GRANT) sw.ack_h[sel_q] = 1'b1;
    end

    // Release and grant touch different outputs: grant needs free=1, release needs free=0.
    always_comb begin
        free_d    = free_q;
        mux_in_d  = mux_in_q;
        mux_out_d = mux_out_q;
        for (int unsigned o = 0; o < NPORT; o++) begin
            if (!free_q[o] && !sw.sender[mux_in_q[o]]) free_d[o] = 1'b1;
        end
        if (state_q == GRANT) begin
            free_d[target_q]   = 1'b0;
            mux_in_d[target_q] = sel_q;
            mux_out_d[sel_q]   = target_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= port_idx_t'(NPORT - 1);
            sel_q     <= '0;
            target_q  <= '0;
            free_q    <= '1;
            mux_in_q  <= '{default: '0};
            mux_out_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            free_q    <= free_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
        end
    end

    always_comb begin
        sw.free    = free_q;
        sw.mux_in  = '0;
        sw.mux_out = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            sw.mux_in[i*PORT_W +: PORT_W]  = mux_in_q[i];
            sw.mux_out[i*PORT_W +: PORT_W] = mux_out_q[i];
        end
    end

endmodule
